alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 64-bit unsigned multiply (low 64 bits of the product) by sequencing the shared 64-bit ALU through shift-add iterations.
- Sits beside the execute stage. It borrows the ALU through a select line (alu_sel) that the datapath uses to mux ALU inputs.
- Takes operands over a valid/ready input handshake and returns the product and a zero flag over a valid/ready output handshake.

Parameters:
- N, 64, datapath and ALU width in bits.
- CW, $clog2(N)+1, width of the iteration counter.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset_L  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept operands.
- op_a  input  N  multiplicand.
- op_b  input  N  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- result  output  N  product, low N bits.
- result_zero  output  1  result == 0.
- alu_sel  output  1  sequencer owns the ALU; datapath muxes alu_a, alu_b and alu_ctrl into the ALU.
- alu_a  output  N  ALU BusA drive.
- alu_b  output  N  ALU BusB drive.
- alu_ctrl  output  4  ALU opcode drive.
- alu_w  input  N  ALU BusW result.

Behaviour:
- Clock and reset: one clock, CLK. Reset_L is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, result=0, result_zero=0, out_valid=0, alu_sel=0, alu_ctrl=PassB (4'b0111).
- State IDLE:
  - in_ready=1.
  - On in_valid: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0.
  - If op_b==0, go to DONE; otherwise go to CALC.
- State CALC:
  - alu_sel=1, alu_ctrl=ADD (4'b0010), alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Each cycle: acc<=alu_w, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Exit to DONE when (mplier>>1)==0 (early termination) or cnt==N-1.
- State DONE:
  - out_valid=1, result=acc, result_zero=(acc==0).
  - On out_ready, go to IDLE.
  - result and result_zero hold stable while out_ready is low.
- Outside CALC: alu_sel=0, alu_a=0, alu_b=0, alu_ctrl=PassB.
- Latency:
  - Let k = index of the highest set bit of op_b, plus 1 (k=0 when op_b==0). Range 0..N.
  - With the accept edge at T, CALC occupies T+1..T+k and out_valid rises at T+k+1.
  - Worst case is N+1 cycles.
- Arithmetic: all adds wrap modulo 2^N, and result is the low N bits of op_a*op_b. Signed operands give correct low bits (two's complement).
- ALU timing: alu_w is sampled at the end of every CALC cycle. The CLK period must exceed the ALU propagation delay (20 ns). CALC must never sample alu_w in the same cycle alu_sel rises without a full period elapsing.
- Boundary conditions:
  - in_ready=0 in CALC and DONE; in_valid there is ignored and the operands are not latched.
  - out_ready with no out_valid has no effect.
  - A new operation is accepted no earlier than the cycle after DONE→IDLE; no bypass.
  - Reset asserted mid-CALC or in DONE aborts immediately to reset values. No partial result is ever presented.
  - op_a==0 runs the full k iterations and yields 0 with result_zero=1.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, PassB 4'b0111.
  - Sequencer state encoding: IDLE, CALC, DONE.
- No sub-module: the ALU itself is instantiated in the datapath and reached through the alu_* ports. The bench instantiates alu_mul_sequencer plus one ALU wired through the alu_sel mux.

Test Plan:
- op_a=3, op_b=5, out_ready=1 -> CALC 3 cycles, out_valid at T+4, result=15, result_zero=0.
- op_b=0, op_a=0xDEAD -> no CALC, out_valid at T+1, result=0, result_zero=1, alu_sel never asserted.
- op_a=0x8000_0000_0000_0000, op_b=2 -> 2 iterations, result=0 (wrap), result_zero=1.
- op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> 64 iterations, out_valid at T+65, result=1.
- op_a=7, op_b=6, out_ready held low 10 cycles after out_valid -> result=42 stable throughout, in_ready=0, a new in_valid is ignored; out_ready=1 then returns to IDLE.
- op_b=0xFF, Reset_L pulsed low during the 4th CALC cycle -> all outputs at reset values immediately; in_ready=1 after release; the next op 2*3 returns 6.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes and multiply-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_sequencer.sv
// ============================================================================
// Module      : alu_mul_sequencer
// Description : Shift-add 64-bit multiply sequenced through the shared ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int N  = 64,
   parameter int CW = $clog2(N) + 1
) (
   input  logic         CLK,
   input  logic         Reset_L,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         result_zero,
   output logic         alu_sel,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   input  logic [N-1:0] alu_w
);

   seq_state_t    r_state;
   logic [N-1:0]  r_acc;
   logic [N-1:0]  r_mcand;
   logic [N-1:0]  r_mplier;
   logic [CW-1:0] r_cnt;
   logic          w_last;

   // Stop as soon as no multiplier bits remain above the one consumed now.
   assign w_last   = (r_mplier[N-1:1] == '0) || (r_cnt == CW'(N - 1));

   assign in_ready = (r_state == IDLE);
   assign alu_a    = (r_state == CALC) ? r_acc : '0;
   assign alu_b    = (r_state == CALC && r_mplier[0]) ? r_mcand : '0;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         result      <= '0;
         result_zero <= 1'b0;
         out_valid   <= 1'b0;
         alu_sel     <= 1'b0;
         alu_ctrl    <= ALU_PASSB;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand  <= op_a;
                  r_mplier <= op_b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  if (op_b == '0) begin
                     r_state     <= DONE;
                     out_valid   <= 1'b1;
                     result      <= '0;
                     result_zero <= 1'b1;
                  end else begin
                     r_state  <= CALC;
                     alu_sel  <= 1'b1;
                     alu_ctrl <= ALU_ADD;
                  end
               end
            end
            CALC: begin
               r_acc    <= alu_w;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state     <= DONE;
                  alu_sel     <= 1'b0;
                  alu_ctrl    <= ALU_PASSB;
                  out_valid   <= 1'b1;
                  result      <= alu_w;
                  result_zero <= (alu_w == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state   <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// ============================================================================
// Module      : tb_alu_mul_sequencer
// Description : Randomized self-checking bench with ALU and datapath mux model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_sequencer;

   localparam int N = 64;

   logic         CLK = 1'b0;
   logic         Reset_L = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] op_a = '0;
   logic [N-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] result;
   logic         result_zero;
   logic         alu_sel;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_ctrl;
   logic [N-1:0] alu_w;

   // Datapath-side ALU operands used whenever the sequencer does not own the ALU
   logic [N-1:0] dp_a = '0;
   logic [N-1:0] dp_b = '0;
   logic [3:0]   dp_ctrl = 4'b0000;
   logic [N-1:0] mux_a, mux_b;
   logic [3:0]   mux_ctrl;

   int n_checks = 0;
   int n_errors = 0;

   always #25 CLK = ~CLK;

   alu_mul_sequencer #(.N(N)) dut (
      .CLK(CLK), .Reset_L(Reset_L),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_zero(result_zero),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .alu_w(alu_w)
   );

   assign mux_a    = alu_sel ? alu_a    : dp_a;
   assign mux_b    = alu_sel ? alu_b    : dp_b;
   assign mux_ctrl = alu_sel ? alu_ctrl : dp_ctrl;

   always_comb begin
      alu_w = '0;
      case (mux_ctrl)
         4'b0000: alu_w = mux_a & mux_b;
         4'b0001: alu_w = mux_a | mux_b;
         4'b0010: alu_w = mux_a + mux_b;
         4'b0110: alu_w = mux_a - mux_b;
         4'b0111: alu_w = mux_b;
         default: alu_w = '0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int ref_iters(input logic [N-1:0] b);
      int k = 0;
      for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
      return k;
   endfunction

   task automatic scramble_dp();
      dp_a    = {$urandom, $urandom};
      dp_b    = {$urandom, $urandom};
      dp_ctrl = 4'($urandom_range(0, 15));
   endtask

   // One full multiply: accept, count latency, optional output stall, handshake.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
      logic [N-1:0] exp_p;
      int           exp_lat, lat;
      bit           sel_seen;
      exp_p   = a * b;
      exp_lat = ref_iters(b) + 1;
      @(negedge CLK);
      check_eq("in_ready_idle", N'(in_ready), N'(1));
      op_a = a; op_b = b; in_valid = 1'b1; scramble_dp();
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      lat = 1; sel_seen = 1'b0;
      while (!out_valid && lat < N + 10) begin
         if (alu_sel) sel_seen = 1'b1;
         check_eq("in_ready_busy", N'(in_ready), N'(0));
         scramble_dp();
         @(negedge CLK);
         lat++;
      end
      check_eq("latency", N'(lat), N'(exp_lat));
      check_eq("result", result, exp_p);
      check_eq("result_zero", N'(result_zero), N'(exp_p == '0));
      check_eq("alu_sel_used", N'(sel_seen), N'(b != '0));
      check_eq("alu_sel_done", N'(alu_sel), N'(0));
      check_eq("alu_ctrl_done", N'(alu_ctrl), N'(4'b0111));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
         @(negedge CLK);
         check_eq("hold_valid", N'(out_valid), N'(1));
         check_eq("hold_result", result, exp_p);
         check_eq("hold_zero", N'(result_zero), N'(exp_p == '0));
         check_eq("hold_in_ready", N'(in_ready), N'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      check_eq("post_valid", N'(out_valid), N'(0));
      check_eq("post_in_ready", N'(in_ready), N'(1));
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      #60;
      check_eq("rst_in_ready", N'(in_ready), N'(1));
      check_eq("rst_out_valid", N'(out_valid), N'(0));
      check_eq("rst_result", result, '0);
      check_eq("rst_alu_sel", N'(alu_sel), N'(0));
      check_eq("rst_alu_ctrl", N'(alu_ctrl), N'(4'b0111));
      @(negedge CLK);
      Reset_L = 1'b1;

      // out_ready with nothing pending must be harmless
      @(negedge CLK);
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      check_eq("idle_oready_valid", N'(out_valid), N'(0));
      check_eq("idle_oready_in_ready", N'(in_ready), N'(1));

      run_op(64'd3, 64'd5, 0);
      run_op(64'hDEAD, 64'd0, 0);
      run_op(64'h8000_0000_0000_0000, 64'd2, 0);
      run_op('1, '1, 0);
      run_op(64'd7, 64'd6, 10);
      run_op(64'd0, 64'h0000_0000_0001_0001, 1);

      // Reset during the fourth CALC cycle
      @(negedge CLK);
      op_a = 64'h1234_5678; op_b = 64'hFF; in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge CLK);
      check_eq("pre_rst_alu_sel", N'(alu_sel), N'(1));
      Reset_L = 1'b0;
      #1;
      check_eq("arst_out_valid", N'(out_valid), N'(0));
      check_eq("arst_alu_sel", N'(alu_sel), N'(0));
      check_eq("arst_alu_ctrl", N'(alu_ctrl), N'(4'b0111));
      check_eq("arst_alu_a", alu_a, '0);
      check_eq("arst_alu_b", alu_b, '0);
      check_eq("arst_result", result, '0);
      check_eq("arst_zero", N'(result_zero), N'(0));
      @(negedge CLK);
      Reset_L = 1'b1;
      @(negedge CLK);
      check_eq("arst_in_ready", N'(in_ready), N'(1));
      run_op(64'd2, 64'd3, 0);

      for (int t = 0; t < 30; t++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 7) == 0) rb = '0;
         if ($urandom_range(0, 7) == 0) ra = '0;
         run_op(ra, rb, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
